// File: rtl/delay_line_rx.sv
// Delay-line pulse receiver: recovers slot timing from rising edges, samples mid-pulse, assembles MSB-first words.
// Word valid 1 cycle after its last sample point; no backpressure (unacked word is overwritten, overrun flagged). Option: DELAY_LINE_RX_GLITCH_FILTER_EN.
module delay_line_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int PW_WIDTH   = 8,
  parameter int PG_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic [PW_WIDTH-1:0]   pulse_width,
  input  logic [PG_WIDTH-1:0]   pulse_gap,
  input  logic [ADDR_WIDTH-1:0] no_nums,
  output logic [DATA_WIDTH-1:0] rx_num,
  output logic [ADDR_WIDTH-1:0] rx_addr,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  rx_realign
);

  localparam int MW = (PW_WIDTH > PG_WIDTH) ? PW_WIDTH : PG_WIDTH;
  localparam int SW = MW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  line_dly_q, line_dly_d;
  logic [SW-1:0]         slot_ctr_q, slot_ctr_d;
  logic [BW-1:0]         bit_ctr_q, bit_ctr_d;
  logic [ADDR_WIDTH-1:0] word_ctr_q, word_ctr_d;
  logic [ADDR_WIDTH-1:0] rx_addr_q, rx_addr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_num_q, rx_num_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_overrun_q, rx_overrun_d;

  logic                  line, rise, sample, complete;
  logic [SW-1:0]         period_m1, sample_pt, gap_p1, realign_val;
  logic [DATA_WIDTH-1:0] shifted;

`ifdef DELAY_LINE_RX_GLITCH_FILTER_EN
  logic hist1_q, hist1_d, hist2_q, hist2_d;
  // Majority of three consecutive samples rejects any single-cycle glitch.
  assign line = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign line = sync2_q;
`endif

  // Full-width arithmetic: the slot period can exceed either field's range.
  assign period_m1   = SW'(pulse_width) + SW'(pulse_gap) - SW'(1);
  assign sample_pt   = SW'(pulse_gap) + (SW'(pulse_width) >> 1);
  assign gap_p1      = SW'(pulse_gap) + SW'(1);
  assign realign_val = (gap_p1 > period_m1) ? '0 : gap_p1;

  assign rise     = line & ~line_dly_q;
  assign sample   = (slot_ctr_q == sample_pt);
  assign complete = sample & (bit_ctr_q == LAST_BIT);
  assign shifted  = {shift_q[DATA_WIDTH-2:0], line};

  always_comb begin
    sync1_d      = in;
    sync2_d      = sync1_q;
    line_dly_d   = line;
    slot_ctr_d   = slot_ctr_q;
    bit_ctr_d    = bit_ctr_q;
    word_ctr_d   = word_ctr_q;
    shift_d      = shift_q;
    rx_num_d     = rx_num_q;
    rx_addr_d    = rx_addr_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
`ifdef DELAY_LINE_RX_GLITCH_FILTER_EN
    hist1_d      = sync2_q;
    hist2_d      = hist1_q;
`endif

    if (rise) begin
      slot_ctr_d = realign_val;
    end else if (slot_ctr_q >= period_m1) begin
      slot_ctr_d = '0;
    end else begin
      slot_ctr_d = slot_ctr_q + SW'(1);
    end

    if (sample) begin
      shift_d   = shifted;
      bit_ctr_d = (bit_ctr_q == LAST_BIT) ? '0 : bit_ctr_q + BW'(1);
    end

    if (complete) begin
      rx_num_d   = shifted;
      rx_addr_d  = word_ctr_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        rx_overrun_d = 1'b1;
      end
      // >= also recovers if no_nums shrinks below the current index.
      if (no_nums <= ADDR_WIDTH'(1) || word_ctr_q >= no_nums - ADDR_WIDTH'(1)) begin
        word_ctr_d = '0;
      end else begin
        word_ctr_d = word_ctr_q + ADDR_WIDTH'(1);
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      line_dly_q   <= 1'b0;
      slot_ctr_q   <= '0;
      bit_ctr_q    <= '0;
      word_ctr_q   <= '0;
      shift_q      <= '0;
      rx_num_q     <= '0;
      rx_addr_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef DELAY_LINE_RX_GLITCH_FILTER_EN
      hist1_q      <= 1'b0;
      hist2_q      <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      line_dly_q   <= line_dly_d;
      slot_ctr_q   <= slot_ctr_d;
      bit_ctr_q    <= bit_ctr_d;
      word_ctr_q   <= word_ctr_d;
      shift_q      <= shift_d;
      rx_num_q     <= rx_num_d;
      rx_addr_q    <= rx_addr_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
`ifdef DELAY_LINE_RX_GLITCH_FILTER_EN
      hist1_q      <= hist1_d;
      hist2_q      <= hist2_d;
`endif
    end
  end

  assign rx_num     = rx_num_q;
  assign rx_addr    = rx_addr_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_realign = rise & ~reset;

endmodule
